// File: rtl/b2a_share_loader.sv
// b2a_share_loader: serial-to-parallel share collector for the masked B2A
// converter. Shares arrive one per handshake and are stored into a load bank.
// A completed frame moves to an output bank that drives o_b straight from
// flops. The two banks act as a ping-pong pair, so frame n+1 can be collected
// while frame n waits for the downstream enable. Shares are only stored and
// moved, never combined: every bank register of index i is fed only by share
// index i, so no unmasked value ever appears in the datapath.
module b2a_share_loader #(
    parameter int unsigned K_WIDTH  = 32,
    parameter int unsigned N_SHARES = 8,
    parameter int unsigned CNT_W    = $clog2(N_SHARES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [K_WIDTH-1:0]            s_share,
    input  logic                          s_last,
    input  logic                          ena,
    output logic [N_SHARES*K_WIDTH-1:0]   o_b,
    output logic                          dvld,
    output logic                          err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SHARES - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LAST    = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                dvld_q, dvld_d;
    logic                                err_q, err_d;
    logic                                ready_q, ready_d;

    // Load bank collects shares; output bank is what the converter samples.
    logic [N_SHARES-1:0][K_WIDTH-1:0]    load_q;
    logic [N_SHARES-1:0][K_WIDTH-1:0]    out_q;

    // Datapath controls produced by the FSM.
    logic                                accept;
    logic                                consume;
    logic                                load_we;
    logic                                out_copy;
    logic                                out_from_share;

    assign accept  = s_valid & ready_q;
    assign consume = dvld_q & ena;

    // Control registers: state, share index and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            cnt_q   <= '0;
            dvld_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvld_q  <= dvld_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dvld_d         = dvld_q;
        err_d          = 1'b0;
        load_we        = 1'b0;
        out_copy       = 1'b0;
        out_from_share = 1'b0;

        // A consumed frame leaves the output bank unless refilled below.
        if (consume) begin
            dvld_d = 1'b0;
        end

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    if (s_last) begin
                        // Early terminator: drop the partial frame.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        load_we = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_LAST) begin
                            state_d = ST_LAST;
                        end
                    end
                end
            end

            ST_LAST: begin
                if (accept) begin
                    cnt_d = '0;
                    if (s_last) begin
                        load_we = 1'b1;
                        if (!dvld_q || ena) begin
                            // Output bank free or emptied this edge: bypass
                            // the final share straight into its output slot.
                            out_copy       = 1'b1;
                            out_from_share = 1'b1;
                            dvld_d         = 1'b1;
                            state_d        = ST_COLLECT;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end else begin
                        // Missing terminator: drop the frame.
                        err_d   = 1'b1;
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_FULL: begin
                if (consume) begin
                    out_copy = 1'b1;
                    dvld_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d != ST_FULL);
    end

    // Load bank: accepted share lands in the slot selected by the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q <= '0;
        end else if (load_we) begin
            for (int unsigned i = 0; i < N_SHARES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    load_q[i] <= s_share;
                end
            end
        end
    end

    // Output bank: same-index copy from the load bank, last slot may bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (out_copy) begin
            for (int unsigned i = 0; i < N_SHARES - 1; i++) begin
                out_q[i] <= load_q[i];
            end
            out_q[N_SHARES-1] <= out_from_share ? s_share : load_q[N_SHARES-1];
        end
    end

    assign o_b     = out_q;
    assign dvld    = dvld_q;
    assign err     = err_q;
    assign s_ready = ready_q;

endmodule
